// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM pipeline control logic: forwarding mux encodings,
// hazard FSM states and the register number of the PC.
package arm_pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    HZ_RUN,
    HZ_DRAIN
  } hz_state_t;

  localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one Exec operand: Memory stage beats Writeback,
// and the PC is never forwarded.
module fwd_sel
  import arm_pipe_pkg::*;
(
  input  logic [3:0] raE_i,
  input  logic [3:0] rdM_i,
  input  logic [3:0] rdW_i,
  input  logic       regWriteM_i,
  input  logic       regWriteW_i,
  output fwd_sel_t   sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (raE_i != REG_PC) begin
      if (regWriteM_i && (rdM_i == raE_i)) begin
        sel_o = FWD_M;
      end else if (regWriteW_i && (rdW_i == raE_i)) begin
        sel_o = FWD_W;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stalls, branch
// flushes and draining of PC-writing instructions, plus saturating perf counters.
module hazard_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       RdE,
  input  logic [3:0]       RdM,
  input  logic [3:0]       RdW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             CondExE,
  input  logic             BranchTakenE,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             flushE,
  output logic             pc_pendW,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_t        state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0] flushCnt_q, flushCnt_d;
  fwd_sel_t         selA, selB;
  logic             ldStall;

  fwd_sel uFwdA (
    .raE_i       (RA1E),
    .rdM_i       (RdM),
    .rdW_i       (RdW),
    .regWriteM_i (RegWriteM),
    .regWriteW_i (RegWriteW),
    .sel_o       (selA)
  );

  fwd_sel uFwdB (
    .raE_i       (RA2E),
    .rdM_i       (RdM),
    .rdW_i       (RdW),
    .regWriteM_i (RegWriteM),
    .regWriteW_i (RegWriteW),
    .sel_o       (selB)
  );

  assign ldStall = MemtoRegE & RegWriteE & ((RdE == RA1D) | (RdE == RA2D));

  // cnt follows the PC writer through E (0), M (1) and W (2) while draining.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stallF    = 1'b0;
    stallD    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    pc_pendW  = 1'b0;
    forwardAE = selA;
    forwardBE = selB;

    if (state_q == HZ_RUN) begin
      if (BranchTakenE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (ldStall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end else if (PCSrcD) begin
        stallF  = 1'b1;
        flushD  = 1'b1;
        state_d = HZ_DRAIN;
        cnt_d   = 2'd0;
      end
    end else begin
      flushD = 1'b1;
      if (cnt_q >= 2'd2) begin
        pc_pendW = 1'b1;
        state_d  = HZ_RUN;
        cnt_d    = 2'd0;
      end else begin
        stallF = 1'b1;
        cnt_d  = cnt_q + 2'd1;
        if ((cnt_q == 2'd0) && !CondExE) begin
          state_d = HZ_RUN;
          cnt_d   = 2'd0;
        end
      end
      if (BranchTakenE) begin
        stallF = 1'b0;
        flushE = 1'b1;
      end
    end

    if (!reset) begin
      state_d   = HZ_RUN;
      cnt_d     = 2'd0;
      stallF    = 1'b0;
      stallD    = 1'b0;
      flushD    = 1'b1;
      flushE    = 1'b1;
      pc_pendW  = 1'b0;
      forwardAE = FWD_RF;
      forwardBE = FWD_RF;
    end

    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (stallD && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + 1'b1;
    end
    if (flushE && (flushCnt_q != '1)) begin
      flushCnt_d = flushCnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= HZ_RUN;
      cnt_q      <= 2'd0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign stall_cnt = stallCnt_q;
  assign flush_cnt = flushCnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a table of single-cycle vectors for
// forwarding / load-use / branch, then hand-written multi-cycle sequences.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic [3:0]       RA1D, RA2D, RA1E, RA2E, RdE, RdM, RdW;
  logic             RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic             PCSrcD, CondExE, BranchTakenE;
  logic [1:0]       forwardAE, forwardBE;
  logic             stallF, stallD, flushD, flushE, pc_pendW;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int nVec;
  int nMis;

  typedef struct {
    logic [3:0] ra1d, ra2d, ra1e, ra2e, rdE, rdM, rdW;
    logic       regWriteE, regWriteM, regWriteW, memtoRegE, branchTakenE;
    logic [1:0] fA, fB;
    logic       sF, sD, fD, fE;
  } vec_t;

  vec_t vecs[10];

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .RA1D         (RA1D),
    .RA2D         (RA2D),
    .RA1E         (RA1E),
    .RA2E         (RA2E),
    .RdE          (RdE),
    .RdM          (RdM),
    .RdW          (RdW),
    .RegWriteE    (RegWriteE),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .MemtoRegE    (MemtoRegE),
    .PCSrcD       (PCSrcD),
    .CondExE      (CondExE),
    .BranchTakenE (BranchTakenE),
    .forwardAE    (forwardAE),
    .forwardBE    (forwardBE),
    .stallF       (stallF),
    .stallD       (stallD),
    .flushD       (flushD),
    .flushE       (flushE),
    .pc_pendW     (pc_pendW),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    RdE = 4'd0; RdM = 4'd0; RdW = 4'd0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    PCSrcD = 1'b0; CondExE = 1'b1; BranchTakenE = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    RA1D = v.ra1d; RA2D = v.ra2d; RA1E = v.ra1e; RA2E = v.ra2e;
    RdE = v.rdE; RdM = v.rdM; RdW = v.rdW;
    RegWriteE = v.regWriteE; RegWriteM = v.regWriteM; RegWriteW = v.regWriteW;
    MemtoRegE = v.memtoRegE; BranchTakenE = v.branchTakenE;
    PCSrcD = 1'b0; CondExE = 1'b1;
  endtask

  // Holds reset for one cycle (checking the forced outputs) and releases it.
  task automatic doReset(input string tag);
    @(negedge clk);
    clearInputs();
    RA1E = 4'd3; RdM = 4'd3; RegWriteM = 1'b1;
    reset = 1'b0;
    #1;
    checkOutput({tag, " rst flushD"}, 32'(flushD), 32'd1);
    checkOutput({tag, " rst flushE"}, 32'(flushE), 32'd1);
    checkOutput({tag, " rst stallF"}, 32'(stallF), 32'd0);
    checkOutput({tag, " rst fwdA"}, 32'(forwardAE), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    clearInputs();
    #1;
    checkOutput({tag, " rst stall_cnt"}, 32'(stall_cnt), 32'd0);
    checkOutput({tag, " rst flush_cnt"}, 32'(flush_cnt), 32'd0);
  endtask

  initial begin
    nVec = 0;
    nMis = 0;
    reset = 1'b0;
    clearInputs();

    //            ra1d  ra2d  ra1e   ra2e   rdE   rdM    rdW    wE wM wW ld br  fA     fB     sF sD fD fE
    vecs[0] = '{4'd0, 4'd0, 4'd3,  4'd0,  4'd0, 4'd3,  4'd3,  0, 1, 1, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0};
    vecs[1] = '{4'd0, 4'd0, 4'd3,  4'd0,  4'd0, 4'd3,  4'd3,  0, 0, 1, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0};
    vecs[2] = '{4'd0, 4'd0, 4'd15, 4'd15, 4'd0, 4'd15, 4'd15, 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0};
    vecs[3] = '{4'd0, 4'd0, 4'd2,  4'd7,  4'd0, 4'd7,  4'd2,  0, 1, 1, 0, 0, 2'b01, 2'b10, 0, 0, 0, 0};
    vecs[4] = '{4'd0, 4'd0, 4'd0,  4'd0,  4'd0, 4'd9,  4'd0,  0, 0, 1, 0, 0, 2'b01, 2'b01, 0, 0, 0, 0};
    vecs[5] = '{4'd0, 4'd4, 4'd0,  4'd0,  4'd4, 4'd9,  4'd9,  1, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 0, 1};
    vecs[6] = '{4'd4, 4'd0, 4'd0,  4'd0,  4'd4, 4'd9,  4'd9,  0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0};
    vecs[7] = '{4'd0, 4'd4, 4'd0,  4'd0,  4'd4, 4'd9,  4'd9,  1, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0, 1, 1};
    vecs[8] = '{4'd0, 4'd0, 4'd0,  4'd0,  4'd0, 4'd9,  4'd9,  0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 1, 1};
    vecs[9] = '{4'd5, 4'd0, 4'd0,  4'd0,  4'd5, 4'd9,  4'd9,  1, 0, 0, 1, 0, 2'b00, 2'b00, 1, 1, 0, 1};

    doReset("init");

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d forwardAE", i), 32'(forwardAE), 32'(vecs[i].fA));
      checkOutput($sformatf("v%0d forwardBE", i), 32'(forwardBE), 32'(vecs[i].fB));
      checkOutput($sformatf("v%0d stallF", i), 32'(stallF), 32'(vecs[i].sF));
      checkOutput($sformatf("v%0d stallD", i), 32'(stallD), 32'(vecs[i].sD));
      checkOutput($sformatf("v%0d flushD", i), 32'(flushD), 32'(vecs[i].fD));
      checkOutput($sformatf("v%0d flushE", i), 32'(flushE), 32'(vecs[i].fE));
      checkOutput($sformatf("v%0d pc_pendW", i), 32'(pc_pendW), 32'd0);
    end

    // Load-use: one stall cycle, then the load has moved on.
    doReset("ld");
    @(negedge clk);
    MemtoRegE = 1'b1; RegWriteE = 1'b1; RdE = 4'd4; RA2D = 4'd4;
    #1;
    checkOutput("ld stallF", 32'(stallF), 32'd1);
    checkOutput("ld stallD", 32'(stallD), 32'd1);
    checkOutput("ld flushE", 32'(flushE), 32'd1);
    @(negedge clk);
    clearInputs();
    RdM = 4'd4; RegWriteM = 1'b1;
    #1;
    checkOutput("ld after stallF", 32'(stallF), 32'd0);
    checkOutput("ld after stallD", 32'(stallD), 32'd0);
    checkOutput("ld after flushE", 32'(flushE), 32'd0);
    checkOutput("ld stall_cnt", 32'(stall_cnt), 32'd1);

    // Branch beats load-use.
    doReset("br");
    @(negedge clk);
    MemtoRegE = 1'b1; RegWriteE = 1'b1; RdE = 4'd4; RA2D = 4'd4; BranchTakenE = 1'b1;
    #1;
    checkOutput("br flushD", 32'(flushD), 32'd1);
    checkOutput("br flushE", 32'(flushE), 32'd1);
    checkOutput("br stallF", 32'(stallF), 32'd0);
    checkOutput("br stallD", 32'(stallD), 32'd0);
    @(negedge clk);
    clearInputs();
    #1;
    checkOutput("br flush_cnt", 32'(flush_cnt), 32'd1);
    checkOutput("br stall_cnt", 32'(stall_cnt), 32'd0);

    // Full PC drain: writer goes E -> M -> W.
    doReset("drain");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      PCSrcD = (i == 0);
      CondExE = 1'b1;
      #1;
      checkOutput($sformatf("drain c%0d stallF", i), 32'(stallF), 32'(i < 3));
      checkOutput($sformatf("drain c%0d flushD", i), 32'(flushD), 32'(i < 4));
      checkOutput($sformatf("drain c%0d pc_pendW", i), 32'(pc_pendW), 32'(i == 3));
    end

    // Annulled PC writer.
    doReset("annul");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      PCSrcD = (i == 0);
      CondExE = (i != 1);
      #1;
      checkOutput($sformatf("annul c%0d stallF", i), 32'(stallF), 32'(i < 2));
      checkOutput($sformatf("annul c%0d flushD", i), 32'(flushD), 32'(i < 2));
      checkOutput($sformatf("annul c%0d pc_pendW", i), 32'(pc_pendW), 32'd0);
    end

    // Saturate both counters with a held load-use, then reset mid-drain.
    doReset("sat");
    @(negedge clk);
    MemtoRegE = 1'b1; RegWriteE = 1'b1; RdE = 4'd6; RA1D = 4'd6;
    repeat (15) @(negedge clk);
    #1;
    checkOutput("sat stall_cnt at max", 32'(stall_cnt), 32'd15);
    checkOutput("sat flush_cnt at max", 32'(flush_cnt), 32'd15);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("sat stall_cnt held", 32'(stall_cnt), 32'd15);
    checkOutput("sat flush_cnt held", 32'(flush_cnt), 32'd15);

    @(negedge clk);
    clearInputs();
    PCSrcD = 1'b1;
    #1;
    checkOutput("mid enter stallF", 32'(stallF), 32'd1);
    @(negedge clk);
    PCSrcD = 1'b0;
    #1;
    checkOutput("mid cnt0 stallF", 32'(stallF), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("mid rst stallF", 32'(stallF), 32'd0);
    checkOutput("mid rst flushE", 32'(flushE), 32'd1);
    checkOutput("mid rst pc_pendW", 32'(pc_pendW), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("mid after stallF", 32'(stallF), 32'd0);
    checkOutput("mid after flushD", 32'(flushD), 32'd0);
    checkOutput("mid after pc_pendW", 32'(pc_pendW), 32'd0);
    checkOutput("mid after stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("mid after flush_cnt", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("mid later pc_pendW", 32'(pc_pendW), 32'd0);
    checkOutput("mid later flushD", 32'(flushD), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
